// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Optional `BCD_BLANK_EN adds a leading-zero blanking mask output.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BIN_W-1:0]  bin_sr;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     adj;
    logic              sticky;
    logic [CW-1:0]     count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            scratch <= '0;
            sticky  <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    // Bit leaving the top digit means the value no longer fits.
                    {scratch, bin_sr} <= {adj[SW-2:0], bin_sr, 1'b0};
                    sticky            <= sticky | adj[SW-1];
                    count             <= count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              upper_zero;

    // Walk from the top digit down; digit 0 is never blanked.
    always_comb begin
        blank_nxt  = '0;
        upper_zero = 1'b1;
        for (int unsigned j = 0; j < DIGITS - 1; j++) begin
            upper_zero               = upper_zero & (scratch[4*(DIGITS-1-j) +: 4] == 4'd0);
            blank_nxt[DIGITS-1-j]    = upper_zero;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
`ifdef BCD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                bcd_out <= scratch;
                ovf     <= sticky;
`ifdef BCD_BLANK_EN
                blank   <= blank_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance
// run in lockstep and are compared against decimal arithmetic.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
`ifdef BCD_BLANK_EN
    logic [2:0]  blank3;
    logic [1:0]  blank2;
`endif

    int checks   = 0;
    int failures = 0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy3),
        .done    (done3),
        .bcd_out (bcd3),
        .ovf     (ovf3)
`ifdef BCD_BLANK_EN
        ,
        .blank   (blank3)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy2),
        .done    (done2),
        .bcd_out (bcd2),
        .ovf     (ovf2)
`ifdef BCD_BLANK_EN
        ,
        .blank   (blank2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Reference: decimal digits by repeated division.
    function automatic logic [11:0] ref_bcd(input int v, input int d);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return (v >= p);
    endfunction

    function automatic logic [2:0] ref_blank(input int v, input int d);
        logic [2:0] b;
        int         p;
        int         t;
        b = '0;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        t = v % p;
        p = 1;
        for (int i = 1; i < d; i++) begin
            p = p * 10;
            b[i] = ((t / p) == 0);
        end
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start, scramble bin_in after capture, wait (bounded) for done.
    task automatic convert(input int v, output int lat, output int bc);
        start  = 1'b1;
        bin_in = v[7:0];
        tick();
        start  = 1'b0;
        bin_in = 8'($urandom);
        lat    = 0;
        bc     = 0;
        while (done3 !== 1'b1 && lat < 40) begin
            if (busy3 === 1'b1) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done3); end
        checks++; if (bcd3 !== 12'h000) begin failures++; $display("FAIL reset_bcd3: got %h want 000", bcd3); end
        checks++; if (ovf3 !== 1'b0) begin failures++; $display("FAIL reset_ovf3: got %b want 0", ovf3); end
        checks++; if (bcd2 !== 8'h00 || ovf2 !== 1'b0) begin failures++; $display("FAIL reset_dut2: got %h/%b want 00/0", bcd2, ovf2); end
`ifdef BCD_BLANK_EN
        checks++; if (blank3 !== 3'b000) begin failures++; $display("FAIL reset_blank: got %b want 000", blank3); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency;
        int lat, bc;
        convert(255, lat, bc);
        checks++; if (lat !== 9) begin failures++; $display("FAIL lat_255: got %0d want 9", lat); end
        checks++; if (bc !== 8) begin failures++; $display("FAIL busy_cycles_255: got %0d want 8", bc); end
        checks++; if (bcd3 !== 12'h255) begin failures++; $display("FAIL bcd_255: got %h want 255", bcd3); end
        checks++; if (ovf3 !== 1'b0) begin failures++; $display("FAIL ovf_255: got %b want 0", ovf3); end
        tick();
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b want 0", done3); end
        checks++; if (bcd3 !== 12'h255) begin failures++; $display("FAIL bcd_hold: got %h want 255", bcd3); end
    endtask

    task automatic test_zero_small;
        int vals[4] = '{0, 7, 10, 100};
        int lat, bc;
        logic [11:0] exp;
        foreach (vals[k]) begin
            convert(vals[k], lat, bc);
            exp = ref_bcd(vals[k], 3);
            checks++; if (bcd3 !== exp) begin failures++; $display("FAIL small_bcd v=%0d: got %h want %h", vals[k], bcd3, exp); end
            checks++; if (ovf3 !== 1'b0) begin failures++; $display("FAIL small_ovf v=%0d: got %b want 0", vals[k], ovf3); end
`ifdef BCD_BLANK_EN
            checks++; if (blank3 !== ref_blank(vals[k], 3)) begin failures++; $display("FAIL small_blank v=%0d: got %b want %b", vals[k], blank3, ref_blank(vals[k], 3)); end
`endif
        end
    endtask

    task automatic test_ignore_start;
        int lat, bc;
        start  = 1'b1;
        bin_in = 8'd42;
        tick();
        start = 1'b0;
        tick();
        tick();
        start  = 1'b1;
        bin_in = 8'd99;
        tick();
        start = 1'b0;
        lat   = 3;
        while (done3 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 9) begin failures++; $display("FAIL ignore_lat: got %0d want 9", lat); end
        checks++; if (bcd3 !== 12'h042) begin failures++; $display("FAIL ignore_bcd: got %h want 042", bcd3); end
        convert(99, lat, bc);
        checks++; if (lat !== 9) begin failures++; $display("FAIL after_done_lat: got %0d want 9", lat); end
        checks++; if (bcd3 !== 12'h099) begin failures++; $display("FAIL after_done_bcd: got %h want 099", bcd3); end
    endtask

    task automatic test_reset_abort;
        int lat, bc, ndone;
        start  = 1'b1;
        bin_in = 8'd200;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy3); end
        checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", done3); end
        checks++; if (bcd3 !== 12'h000) begin failures++; $display("FAIL abort_bcd: got %h want 000", bcd3); end
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            tick();
            if (done3 === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
        convert(200, lat, bc);
        checks++; if (bcd3 !== 12'h200) begin failures++; $display("FAIL abort_reconvert: got %h want 200", bcd3); end
    endtask

    task automatic test_ovf;
        int lat, bc;
        convert(123, lat, bc);
        checks++; if (bcd2 !== 8'h23) begin failures++; $display("FAIL ovf_bcd_123: got %h want 23", bcd2); end
        checks++; if (ovf2 !== 1'b1) begin failures++; $display("FAIL ovf_flag_123: got %b want 1", ovf2); end
        checks++; if (bcd3 !== 12'h123 || ovf3 !== 1'b0) begin failures++; $display("FAIL wide_123: got %h/%b want 123/0", bcd3, ovf3); end
        convert(99, lat, bc);
        checks++; if (bcd2 !== 8'h99) begin failures++; $display("FAIL ovf_bcd_99: got %h want 99", bcd2); end
        checks++; if (ovf2 !== 1'b0) begin failures++; $display("FAIL ovf_flag_99: got %b want 0", ovf2); end
    endtask

    task automatic test_random;
        int          v, lat, bc;
        logic [11:0] e3, e2;
        repeat (40) begin
            v = int'($urandom_range(0, 255));
            convert(v, lat, bc);
            e3 = ref_bcd(v, 3);
            e2 = ref_bcd(v, 2);
            checks++; if (bcd3 !== e3) begin failures++; $display("FAIL rand_bcd3 v=%0d: got %h want %h", v, bcd3, e3); end
            checks++; if (bcd2 !== e2[7:0] || ovf2 !== ref_ovf(v, 2)) begin failures++; $display("FAIL rand_dut2 v=%0d: got %h/%b want %h/%b", v, bcd2, ovf2, e2[7:0], ref_ovf(v, 2)); end
        end
    endtask

    task automatic test_back_to_back;
        int          lat, bc;
        logic [11:0] e3, e2;
        for (int v = 0; v < 256; v++) begin
            convert(v, lat, bc);
            e3 = ref_bcd(v, 3);
            e2 = ref_bcd(v, 2);
            checks++; if (lat !== 9) begin failures++; $display("FAIL sweep_lat v=%0d: got %0d want 9", v, lat); end
            checks++; if (bcd3 !== e3 || ovf3 !== ref_ovf(v, 3)) begin failures++; $display("FAIL sweep_dut3 v=%0d: got %h/%b want %h/%b", v, bcd3, ovf3, e3, ref_ovf(v, 3)); end
            checks++; if (bcd2 !== e2[7:0] || ovf2 !== ref_ovf(v, 2)) begin failures++; $display("FAIL sweep_dut2 v=%0d: got %h/%b want %h/%b", v, bcd2, ovf2, e2[7:0], ref_ovf(v, 2)); end
`ifdef BCD_BLANK_EN
            e3 = {9'b0, ref_blank(v, 3)};
            e2 = {9'b0, ref_blank(v, 2)};
            checks++; if (blank3 !== e3[2:0] || blank2 !== e2[1:0]) begin failures++; $display("FAIL sweep_blank v=%0d: got %b/%b want %b/%b", v, blank3, blank2, e3[2:0], e2[1:0]); end
`endif
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        test_reset();
        test_latency();
        test_zero_small();
        test_ignore_start();
        test_reset_abort();
        test_ovf();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
